// File: rtl/sumsq_accum.sv
`timescale 1ns/1ps
// sumsq_accum: windowed mean-square accumulator feeding the RMS square root.
// Each accepted signed sample is squared (stage 1). The squares of 2^LOG2N
// accepted samples are summed (stage 2), and the sum is divided by the window
// length with a right shift. The result is published with a one-cycle valid
// pulse. Every output is registered, so no input has a combinational path to
// an output.
module sumsq_accum #(
    parameter int IN_WIDTH = 32,
    parameter int LOG2N    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic signed [IN_WIDTH-1:0] sink,
    input  logic                       sink_valid,
    output logic [2*IN_WIDTH-1:0]      source,
    output logic                       source_valid
);
    localparam int OW = 2 * IN_WIDTH;
    // LOG2N bits of headroom: the sum of N squares cannot overflow.
    localparam int AW = OW + LOG2N;

    logic signed [OW-1:0] sink_ext;
    logic [OW-1:0]        sq;
    logic                 sq_v;
    logic [AW-1:0]        acc;
    logic [LOG2N-1:0]     cnt;
    logic [AW-1:0]        acc_sum;
    logic                 window_done;

    // Sign-extend before multiplying. The full-width product is then exact,
    // and its largest value, 2^(OW-2) from the most negative input, fits.
    assign sink_ext    = OW'(sink);
    assign acc_sum     = acc + AW'(sq);
    assign window_done = sq_v && (cnt == {LOG2N{1'b1}});

    // Stage 1: square each accepted sample.
    // sq_v simply follows sink_valid. A clr on the same edge as an accepted
    // sample therefore keeps that sample, and it becomes sample 0 of the new
    // window. Without a sample, the in-flight square is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq   <= '0;
            sq_v <= 1'b0;
        end else begin
            sq_v <= sink_valid;
            if (sink_valid) begin
                sq <= $unsigned(sink_ext * sink_ext);
            end
        end
    end

    // Stage 2: accumulate N squares, then publish floor(sum / N).
    // clr outranks window completion, so a clr on the completing edge loses
    // the partial sum and produces no pulse. source keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            cnt          <= '0;
            source       <= '0;
            source_valid <= 1'b0;
        end else begin
            source_valid <= 1'b0;
            if (clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (sq_v) begin
                if (window_done) begin
                    source       <= acc_sum[AW-1:LOG2N];
                    source_valid <= 1'b1;
                    acc          <= '0;
                    cnt          <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + LOG2N'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sumsq_accum.sv
`timescale 1ns/1ps
// tb_sumsq_accum: scoreboard bench for sumsq_accum.
// u4 (N=4) covers the directed window, gap, clr and reset scenarios.
// u16 (N=16) is checked against randomly generated windows.
module tb_sumsq_accum;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clr = 1'b0;
    logic               sink_valid = 1'b0;
    logic signed [31:0] sink = '0;
    logic [63:0]        src;
    logic               src_v;

    logic               clr16 = 1'b0;
    logic               v16 = 1'b0;
    logic signed [31:0] sink16 = '0;
    logic [63:0]        src16;
    logic               src_v16;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Expected entries are pushed as stimulus is driven.
    // Observed pulses are pushed by the monitor.
    logic [63:0] exp_val[$];
    int          exp_cyc[$];
    logic [63:0] obs_val[$];
    int          obs_cyc[$];
    logic [63:0] exp16[$];
    logic [63:0] obs16[$];

    sumsq_accum #(.IN_WIDTH(32), .LOG2N(2)) u4 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .sink(sink), .sink_valid(sink_valid),
        .source(src), .source_valid(src_v)
    );

    sumsq_accum #(.IN_WIDTH(32), .LOG2N(4)) u16 (
        .clk(clk), .rst_n(rst_n), .clr(clr16), .sink(sink16), .sink_valid(v16),
        .source(src16), .source_valid(src_v16)
    );

    always #5 clk = ~clk;

    // Count rising edges so that pulse timing can be checked.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid pulse, sampled away from the rising edge.
    always @(negedge clk) begin
        if (src_v === 1'b1) begin
            obs_val.push_back(src);
            obs_cyc.push_back(cyc);
        end
        if (src_v16 === 1'b1) obs16.push_back(src16);
    end

    // Drive one cycle of u4 inputs.
    // e returns the index of the rising edge that accepted them.
    task automatic step(input logic v, input logic signed [31:0] d, input logic c, output int e);
        @(negedge clk);
        sink_valid = v;
        sink       = d;
        clr        = c;
        @(posedge clk);
        #1;
        e = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sink_valid = 1'b0;
            clr        = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (src !== 64'd0 || src_v !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_u4: source=%0d valid=%b, required 0/0", src, src_v);
        end
        n_cmp++;
        if (src16 !== 64'd0 || src_v16 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_u16: source=%0d valid=%b, required 0/0", src16, src_v16);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int e, oc, ec;
        logic [63:0] ov, ev;
        step(1, 3, 0, e);
        step(1, -4, 0, e);
        step(1, 5, 0, e);
        step(1, -6, 0, e);
        exp_val.push_back(64'd21);
        exp_cyc.push_back(e + 1);
        idle(4);
        while (exp_val.size() > 0) begin
            ev = exp_val.pop_front();
            ec = exp_cyc.pop_front();
            n_cmp++;
            if (obs_val.size() == 0) begin
                n_bad++;
                $display("FAIL basic_pulse: no pulse, required source=%0d at edge %0d", ev, ec);
            end else begin
                ov = obs_val.pop_front();
                oc = obs_cyc.pop_front();
                if (ov !== ev || oc != ec) begin
                    n_bad++;
                    $display("FAIL basic_pulse: source=%0d at edge %0d, required %0d at edge %0d", ov, oc, ev, ec);
                end
            end
        end
        n_cmp++;
        if (obs_val.size() != 0) begin
            n_bad++;
            $display("FAIL basic_extra: %0d extra pulses, required 0", obs_val.size());
        end
        obs_val.delete();
        obs_cyc.delete();
        n_cmp++;
        if (src !== 64'd21) begin
            n_bad++;
            $display("FAIL basic_hold: source=%0d, required 21", src);
        end
    endtask

    task automatic test_extremes();
        int e, oc, ec;
        logic [63:0] ov, ev;
        for (int i = 0; i < 4; i++) step(1, 32'sh8000_0000, 0, e);
        exp_val.push_back(64'h4000_0000_0000_0000);
        exp_cyc.push_back(e + 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, e);
        exp_val.push_back(64'd0);
        exp_cyc.push_back(e + 1);
        idle(4);
        while (exp_val.size() > 0) begin
            ev = exp_val.pop_front();
            ec = exp_cyc.pop_front();
            n_cmp++;
            if (obs_val.size() == 0) begin
                n_bad++;
                $display("FAIL extremes_pulse: no pulse, required source=%0h at edge %0d", ev, ec);
            end else begin
                ov = obs_val.pop_front();
                oc = obs_cyc.pop_front();
                if (ov !== ev || oc != ec) begin
                    n_bad++;
                    $display("FAIL extremes_pulse: source=%0h at edge %0d, required %0h at edge %0d", ov, oc, ev, ec);
                end
            end
        end
        n_cmp++;
        if (obs_val.size() != 0) begin
            n_bad++;
            $display("FAIL extremes_extra: %0d extra pulses, required 0", obs_val.size());
        end
        obs_val.delete();
        obs_cyc.delete();
    endtask

    task automatic test_gaps();
        int e, oc, ec;
        logic [63:0] ov, ev;
        step(1, 1, 0, e);
        idle(3);
        step(1, 2, 0, e);
        step(1, 3, 0, e);
        idle(5);
        step(1, 4, 0, e);
        exp_val.push_back(64'd7);
        exp_cyc.push_back(e + 1);
        idle(4);
        while (exp_val.size() > 0) begin
            ev = exp_val.pop_front();
            ec = exp_cyc.pop_front();
            n_cmp++;
            if (obs_val.size() == 0) begin
                n_bad++;
                $display("FAIL gaps_pulse: no pulse, required source=%0d at edge %0d", ev, ec);
            end else begin
                ov = obs_val.pop_front();
                oc = obs_cyc.pop_front();
                if (ov !== ev || oc != ec) begin
                    n_bad++;
                    $display("FAIL gaps_pulse: source=%0d at edge %0d, required %0d at edge %0d", ov, oc, ev, ec);
                end
            end
        end
        n_cmp++;
        if (obs_val.size() != 0) begin
            n_bad++;
            $display("FAIL gaps_extra: %0d extra pulses, required 0", obs_val.size());
        end
        obs_val.delete();
        obs_cyc.delete();
    endtask

    task automatic test_clr();
        int e, oc, ec;
        logic [63:0] ov, ev;
        // clr arrives with a sample: that sample starts the new window.
        step(1, 10, 0, e);
        step(1, 10, 0, e);
        step(1, 2, 1, e);
        for (int i = 0; i < 3; i++) step(1, 2, 0, e);
        exp_val.push_back(64'd4);
        exp_cyc.push_back(e + 1);
        idle(3);
        // clr with the 4th sample: no pulse. That sample becomes sample 0.
        for (int i = 0; i < 3; i++) step(1, 7, 0, e);
        step(1, 7, 1, e);
        idle(4);
        // Three more samples complete the window, but clr lands on the
        // completing edge, so no pulse is produced.
        for (int i = 0; i < 3; i++) step(1, 7, 0, e);
        step(0, 0, 1, e);
        idle(4);
        n_cmp++;
        if (src !== 64'd4) begin
            n_bad++;
            $display("FAIL clr_hold: source=%0d, required 4", src);
        end
        // A clean window after the clears: (4*36)/4 = 36.
        for (int i = 0; i < 4; i++) step(1, -6, 0, e);
        exp_val.push_back(64'd36);
        exp_cyc.push_back(e + 1);
        idle(3);
        while (exp_val.size() > 0) begin
            ev = exp_val.pop_front();
            ec = exp_cyc.pop_front();
            n_cmp++;
            if (obs_val.size() == 0) begin
                n_bad++;
                $display("FAIL clr_pulse: no pulse, required source=%0d at edge %0d", ev, ec);
            end else begin
                ov = obs_val.pop_front();
                oc = obs_cyc.pop_front();
                if (ov !== ev || oc != ec) begin
                    n_bad++;
                    $display("FAIL clr_pulse: source=%0d at edge %0d, required %0d at edge %0d", ov, oc, ev, ec);
                end
            end
        end
        n_cmp++;
        if (obs_val.size() != 0) begin
            n_bad++;
            $display("FAIL clr_extra: %0d extra pulses, required 0", obs_val.size());
        end
        obs_val.delete();
        obs_cyc.delete();
    endtask

    task automatic test_async_reset();
        int e, oc, ec;
        logic [63:0] ov, ev;
        step(1, 100, 0, e);
        step(1, 100, 0, e);
        // Assert reset between edges; the outputs must clear without a clock edge.
        #2;
        rst_n      = 1'b0;
        sink_valid = 1'b0;
        #1;
        n_cmp++;
        if (src !== 64'd0 || src_v !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: source=%0d valid=%b, required 0/0", src, src_v);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1, 1, 0, e);
        exp_val.push_back(64'd1);
        exp_cyc.push_back(e + 1);
        idle(3);
        while (exp_val.size() > 0) begin
            ev = exp_val.pop_front();
            ec = exp_cyc.pop_front();
            n_cmp++;
            if (obs_val.size() == 0) begin
                n_bad++;
                $display("FAIL reset_pulse: no pulse, required source=%0d at edge %0d", ev, ec);
            end else begin
                ov = obs_val.pop_front();
                oc = obs_cyc.pop_front();
                if (ov !== ev || oc != ec) begin
                    n_bad++;
                    $display("FAIL reset_pulse: source=%0d at edge %0d, required %0d at edge %0d", ov, oc, ev, ec);
                end
            end
        end
        n_cmp++;
        if (obs_val.size() != 0) begin
            n_bad++;
            $display("FAIL reset_extra: %0d extra pulses, required 0", obs_val.size());
        end
        obs_val.delete();
        obs_cyc.delete();
    endtask

    task automatic test_random16();
        logic signed [31:0] x;
        longint             xl;
        logic [67:0]        sum;
        logic [63:0]        ov, ev;
        int                 r;
        for (int w = 0; w < 60; w++) begin
            sum = '0;
            for (int i = 0; i < 16; i++) begin
                r = $urandom_range(0, 9);
                if (w == 0) x = 32'sd1000;
                else if (r == 0) x = 32'sh8000_0000;
                else if (r == 1) x = 32'sh7fff_ffff;
                else x = $urandom;
                xl = longint'(x);
                sum = sum + 68'(64'(xl * xl));
                @(negedge clk);
                if ($urandom_range(0, 3) == 0) begin
                    v16 = 1'b0;
                    @(negedge clk);
                end
                v16    = 1'b1;
                sink16 = x;
            end
            exp16.push_back(64'(sum >> 4));
        end
        @(negedge clk);
        v16 = 1'b0;
        repeat (4) @(negedge clk);
        while (exp16.size() > 0) begin
            ev = exp16.pop_front();
            n_cmp++;
            if (obs16.size() == 0) begin
                n_bad++;
                $display("FAIL random16: no pulse, required source=%0d", ev);
            end else begin
                ov = obs16.pop_front();
                if (ov !== ev) begin
                    n_bad++;
                    $display("FAIL random16: source=%0d, required %0d", ov, ev);
                end
            end
        end
        n_cmp++;
        if (obs16.size() != 0) begin
            n_bad++;
            $display("FAIL random16_extra: %0d extra pulses, required 0", obs16.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_gaps();
        test_clr();
        test_async_reset();
        test_random16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Stop a hung run instead of letting it wait forever.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
